// File: rtl/apb4_clint_mh_if.sv
// APB4 bus bundle shared by the CLINT and its bus master; carries the bus clock
// and active-low reset alongside the usual APB4 signals.
interface apb4_if;
  logic        hclk;
  logic        hresetn;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport slave (
    input  hclk, hresetn, paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );

  modport master (
    input  hclk, hresetn, prdata, pready, pslverr,
    output paddr, pwdata, pwrite, psel, penable
  );
endinterface

// File: rtl/apb4_clint_mh.sv
// Multi-hart CLINT on APB4: per-hart MSIP and MTIMECMP, a shared 64-bit mtime
// ticked either by a synchronised RTC input or by an internal hclk prescaler.
module apb4_clint_mh #(
  parameter int unsigned HART_NUM   = 4,
  parameter int unsigned PSCR_WIDTH = 16
) (
  apb4_if.slave               apb4,
  input  logic                rtc_clk_i,
  output logic [HART_NUM-1:0] tmr_irq_o,
  output logic [HART_NUM-1:0] sfr_irq_o
);
  localparam logic [5:0] OFF_CTRL = 6'h10;
  localparam logic [5:0] OFF_PSCR = 6'h11;
  localparam logic [5:0] OFF_MTL  = 6'h12;
  localparam logic [5:0] OFF_MTH  = 6'h13;

  logic                  clk, rst_n;
  logic [5:0]            off;
  logic                  acc, wr_en, rd_en, mapped;
  logic [HART_NUM-1:0]   hit_msip, hit_cmpl, hit_cmph;
  logic                  hit_ctrl, hit_pscr, hit_mtl, hit_mth;

  logic [HART_NUM-1:0]   msip_q;
  logic                  en_q, src_q;
  logic [PSCR_WIDTH-1:0] pscr_q, cnt_q, cnt_d;
  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           cmp_q [HART_NUM];
  logic [HART_NUM-1:0]   tmr_irq_q;
  logic                  sync1_q, sync2_q, prev_q, armed_q;
  logic [1:0]            warm_q;
  logic                  rtc_tick, presc_run, presc_tick, inc;

  assign clk   = apb4.hclk;
  assign rst_n = apb4.hresetn;
  assign off   = apb4.paddr[7:2];

  always_comb begin
    hit_msip = '0;
    hit_cmpl = '0;
    hit_cmph = '0;
    for (int unsigned h = 0; h < HART_NUM; h++) begin
      hit_msip[h] = (off == 6'(h));
      hit_cmpl[h] = (off == 6'(32 + 2 * h));
      hit_cmph[h] = (off == 6'(33 + 2 * h));
    end
  end

  assign hit_ctrl = (off == OFF_CTRL);
  assign hit_pscr = (off == OFF_PSCR);
  assign hit_mtl  = (off == OFF_MTL);
  assign hit_mth  = (off == OFF_MTH);
  assign mapped   = (|hit_msip) | (|hit_cmpl) | (|hit_cmph) |
                    hit_ctrl | hit_pscr | hit_mtl | hit_mth;

  assign acc          = apb4.psel & apb4.penable;
  assign wr_en        = acc & apb4.pwrite & mapped;
  assign rd_en        = acc & ~apb4.pwrite & mapped;
  assign apb4.pready  = 1'b1;
  assign apb4.pslverr = acc & ~mapped;

  always_comb begin
    apb4.prdata = '0;
    if (rd_en) begin
      if (hit_ctrl) apb4.prdata = {30'd0, src_q, en_q};
      if (hit_pscr) apb4.prdata = 32'(pscr_q);
      if (hit_mtl)  apb4.prdata = mtime_q[31:0];
      if (hit_mth)  apb4.prdata = mtime_q[63:32];
      for (int unsigned h = 0; h < HART_NUM; h++) begin
        if (hit_msip[h]) apb4.prdata = {31'd0, msip_q[h]};
        if (hit_cmpl[h]) apb4.prdata = cmp_q[h][31:0];
        if (hit_cmph[h]) apb4.prdata = cmp_q[h][63:32];
      end
    end
  end

  // An RTC edge only counts once a genuine low has been sampled after reset,
  // so an rtc_clk_i held high across reset release does not produce a tick.
  assign rtc_tick   = sync2_q & ~prev_q & armed_q;
  assign presc_run  = en_q & src_q;
  assign presc_tick = presc_run & (cnt_q == pscr_q);
  assign inc        = en_q & (src_q ? presc_tick : rtc_tick);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!presc_run || presc_tick || (wr_en && (hit_ctrl || hit_pscr))) cnt_d = '0;
  end

  // A write to either half wins over a same-cycle increment; that tick is lost.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_en && hit_mtl)      mtime_d[31:0]  = apb4.pwdata;
    else if (wr_en && hit_mth) mtime_d[63:32] = apb4.pwdata;
    else if (inc)              mtime_d        = mtime_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msip_q    <= '0;
      en_q      <= 1'b1;
      src_q     <= 1'b0;
      pscr_q    <= '0;
      cnt_q     <= '0;
      mtime_q   <= '0;
      tmr_irq_q <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      armed_q   <= 1'b0;
      warm_q    <= '0;
      for (int unsigned h = 0; h < HART_NUM; h++) cmp_q[h] <= '1;
    end else begin
      sync1_q <= rtc_clk_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      warm_q  <= {warm_q[0], 1'b1};
      armed_q <= armed_q | (warm_q[1] & ~sync2_q);
      cnt_q   <= cnt_d;
      mtime_q <= mtime_d;
      if (wr_en && hit_ctrl) begin
        en_q  <= apb4.pwdata[0];
        src_q <= apb4.pwdata[1];
      end
      if (wr_en && hit_pscr) pscr_q <= apb4.pwdata[PSCR_WIDTH-1:0];
      for (int unsigned h = 0; h < HART_NUM; h++) begin
        if (wr_en && hit_msip[h]) msip_q[h]        <= apb4.pwdata[0];
        if (wr_en && hit_cmpl[h]) cmp_q[h][31:0]  <= apb4.pwdata;
        if (wr_en && hit_cmph[h]) cmp_q[h][63:32] <= apb4.pwdata;
        tmr_irq_q[h] <= (mtime_q >= cmp_q[h]);
      end
    end
  end

  assign tmr_irq_o = tmr_irq_q;
  assign sfr_irq_o = msip_q;
endmodule

// File: tb/tb_apb4_clint_mh.sv
// Self-checking bench for apb4_clint_mh: vector table, directed timing sequences
// and randomised register traffic against an abstract register-map model.
module tb_apb4_clint_mh;
  localparam int unsigned H = 4;

  apb4_if bus ();
  logic         rtc;
  logic [H-1:0] tmr, sfr;
  int           n_checks = 0;
  int           n_fail   = 0;

  apb4_clint_mh #(.HART_NUM(H), .PSCR_WIDTH(16)) dut (
    .apb4      (bus),
    .rtc_clk_i (rtc),
    .tmr_irq_o (tmr),
    .sfr_irq_o (sfr)
  );

  initial bus.hclk = 1'b0;
  always #5 bus.hclk = ~bus.hclk;

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err);
    @(negedge bus.hclk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = wdata;
    @(negedge bus.hclk);
    bus.penable = 1'b1;
    #1;
    rdata = bus.prdata;
    err   = bus.pslverr;
    @(negedge bus.hclk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d);
    logic [31:0] r; logic e;
    apb(1'b1, addr, d, r, e);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] r; logic e;
    apb(1'b0, addr, 32'h0, r, e);
    check(name, r, exp);
  endtask

  task automatic rtc_pulse();
    @(negedge bus.hclk); rtc = 1'b1;
    repeat (6) @(negedge bus.hclk);
    rtc = 1'b0;
    repeat (5) @(negedge bus.hclk);
  endtask

  // Abstract model of the register map
  bit          m_msip [H];
  logic [63:0] m_cmp  [H];
  logic [63:0] m_mtime;
  bit          m_en, m_src;
  logic [15:0] m_pscr;

  task automatic model_access(input bit w, input int off, input logic [31:0] d,
                              output logic [31:0] r, output bit err);
    int h;
    err = 1'b1; r = 32'h0;
    if (off < 16) begin
      if (off < H) begin
        err = 1'b0;
        if (w) m_msip[off] = d[0];
        r = {31'd0, m_msip[off]};
      end
    end else if (off == 16) begin
      err = 1'b0;
      if (w) begin m_en = d[0]; m_src = d[1]; end
      r = {30'd0, m_src, m_en};
    end else if (off == 17) begin
      err = 1'b0;
      if (w) m_pscr = d[15:0];
      r = {16'd0, m_pscr};
    end else if (off == 18 || off == 19) begin
      err = 1'b0;
      if (w) begin
        if (off == 18) m_mtime = {m_mtime[63:32], d};
        else           m_mtime = {d, m_mtime[31:0]};
      end
      r = (off == 18) ? m_mtime[31:0] : m_mtime[63:32];
    end else if (off >= 32) begin
      h = (off - 32) / 2;
      if (h < H) begin
        err = 1'b0;
        if (w) begin
          if (off % 2 == 0) m_cmp[h] = {m_cmp[h][63:32], d};
          else              m_cmp[h] = {d, m_cmp[h][31:0]};
        end
        r = (off % 2 == 0) ? m_cmp[h][31:0] : m_cmp[h][63:32];
      end
    end
    if (w) r = 32'h0;
  endtask

  typedef struct {
    bit          w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] r, d, rnd, addr;
    logic        e;
    logic [31:0] mr;
    bit          me;
    logic [H-1:0] exp_tmr, exp_sfr;
    int          off;

    bus.hresetn = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0; rtc = 1'b0;
    repeat (3) @(negedge bus.hclk);
    bus.hresetn = 1'b1;
    repeat (4) @(negedge bus.hclk);

    // Reset state
    check("reset_tmr", tmr, 0);
    check("reset_sfr", sfr, 0);
    rd_chk("reset_cmpl0", 32'h80, 32'hFFFF_FFFF);
    rd_chk("reset_cmph0", 32'h84, 32'hFFFF_FFFF);
    rd_chk("reset_ctrl", 32'h40, 32'h1);
    rd_chk("reset_mtl", 32'h48, 32'h0);

    // Stateful vector table: decode, aliasing, half writes, errors
    tbl.push_back('{1'b1, 32'h40,  32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h40,  32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b1, 32'h44,  32'hABCD_1234, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h44,  32'h0,         32'h1234,      1'b0});
    tbl.push_back('{1'b0, 32'h345, 32'h0,         32'h1234,      1'b0});
    tbl.push_back('{1'b1, 32'h60,  32'hDEAD_BEEF, 32'h0,         1'b1});
    tbl.push_back('{1'b0, 32'h60,  32'h0,         32'h0,         1'b1});
    tbl.push_back('{1'b1, 32'h10,  32'h1,         32'h0,         1'b1});
    tbl.push_back('{1'b0, 32'h10,  32'h0,         32'h0,         1'b1});
    tbl.push_back('{1'b0, 32'h00,  32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b1, 32'h04,  32'hFFFF_FFFF, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h04,  32'h0,         32'h1,         1'b0});
    tbl.push_back('{1'b1, 32'h04,  32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h04,  32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b1, 32'h90,  32'h1111_1111, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h90,  32'h0,         32'h1111_1111, 1'b0});
    tbl.push_back('{1'b0, 32'h94,  32'h0,         32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{1'b1, 32'h94,  32'h22,        32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h94,  32'h0,         32'h22,        1'b0});
    tbl.push_back('{1'b0, 32'h90,  32'h0,         32'h1111_1111, 1'b0});
    tbl.push_back('{1'b1, 32'hA0,  32'h5,         32'h0,         1'b1});
    tbl.push_back('{1'b0, 32'hA0,  32'h0,         32'h0,         1'b1});
    tbl.push_back('{1'b0, 32'hA4,  32'h0,         32'h0,         1'b1});
    tbl.push_back('{1'b0, 32'h50,  32'h0,         32'h0,         1'b1});
    tbl.push_back('{1'b0, 32'h7C,  32'h0,         32'h0,         1'b1});
    tbl.push_back('{1'b1, 32'h4C,  32'hCAFE,      32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h4C,  32'h0,         32'hCAFE,      1'b0});
    tbl.push_back('{1'b0, 32'h48,  32'h0,         32'h0,         1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      apb(tbl[i].w, tbl[i].addr, tbl[i].wdata, r, e);
      check($sformatf("tbl%0d_rdata", i), r, tbl[i].rdata);
      check($sformatf("tbl%0d_err", i), e, tbl[i].err);
    end
    @(negedge bus.hclk);
    check("tbl_sfr_after_bad_msip", sfr, 0);
    check("tbl_tmr_cmp2_below_mtime", tmr, 4'b0100);

    // Software interrupt
    wr(32'h08, 32'hFFFF_FFFF);
    rd_chk("msip2_read", 32'h08, 32'h1);
    check("msip2_sfr", sfr, 4'b0100);
    wr(32'h08, 32'h0);
    check("msip2_clear", sfr, 0);

    // Prescaled tick, PSCR=3: one increment per 4 cycles
    wr(32'h40, 32'h0); wr(32'h48, 32'h0); wr(32'h4C, 32'h0);
    wr(32'h44, 32'h3); wr(32'h40, 32'h3);
    repeat (39) @(posedge bus.hclk);
    rd_chk("presc3_mtl", 32'h48, 32'd10);
    rd_chk("presc3_mth", 32'h4C, 32'd0);
    // PSCR=0: one increment per cycle
    wr(32'h40, 32'h2); wr(32'h48, 32'h0); wr(32'h4C, 32'h0);
    wr(32'h44, 32'h0); wr(32'h40, 32'h3);
    repeat (9) @(posedge bus.hclk);
    rd_chk("presc0_mtl", 32'h48, 32'd10);

    // Timer interrupt from the RTC source
    wr(32'h40, 32'h0); wr(32'h48, 32'h0); wr(32'h4C, 32'h0);
    wr(32'h8C, 32'h0); wr(32'h88, 32'h5);
    wr(32'h40, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge bus.hclk); rtc = 1'b1;
      repeat (3) @(negedge bus.hclk);
      check($sformatf("tmr1_pre_tick%0d", k), tmr[1], 1'b0);
      @(negedge bus.hclk);
      check($sformatf("tmr1_post_tick%0d", k), tmr[1], (k >= 5) ? 1'b1 : 1'b0);
      check($sformatf("tmr0_tick%0d", k), tmr[0], 1'b0);
      rtc = 1'b0;
      repeat (4) @(negedge bus.hclk);
    end
    rd_chk("rtc_mtl_5", 32'h48, 32'd5);
    wr(32'h88, 32'd100);
    check("tmr1_hold_after_raise", tmr[1], 1'b1);
    @(negedge bus.hclk);
    check("tmr1_clear_after_raise", tmr[1], 1'b0);

    // 64-bit wrap
    wr(32'h40, 32'h0); wr(32'h4C, 32'hFFFF_FFFF); wr(32'h48, 32'hFFFF_FFFF);
    wr(32'h40, 32'h1);
    rtc_pulse();
    rd_chk("wrap_mtl", 32'h48, 32'h0);
    rd_chk("wrap_mth", 32'h4C, 32'h0);

    // MTIMEL write landing on the same edge as an RTC increment
    wr(32'h40, 32'h0); wr(32'h48, 32'h10); wr(32'h4C, 32'h7); wr(32'h40, 32'h1);
    @(negedge bus.hclk); rtc = 1'b1;
    wr(32'h48, 32'h1234);
    repeat (3) @(negedge bus.hclk);
    rtc = 1'b0;
    repeat (4) @(negedge bus.hclk);
    rd_chk("collide_mtl", 32'h48, 32'h1234);
    rd_chk("collide_mth", 32'h4C, 32'h7);

    // Randomised register traffic with mtime frozen (EN=0)
    m_en = 1'b0; m_src = 1'b0; m_pscr = '0; m_mtime = '0;
    wr(32'h40, 32'h0); wr(32'h44, 32'h0); wr(32'h48, 32'h0); wr(32'h4C, 32'h0);
    for (int h = 0; h < H; h++) begin
      m_msip[h] = 1'b0; m_cmp[h] = 64'd0;
      wr(32'(4 * h), 32'h0);
      wr(32'(32'h80 + 8 * h), 32'h0);
      wr(32'(32'h84 + 8 * h), 32'h0);
    end
    for (int it = 0; it < 250; it++) begin
      off = $urandom_range(0, 63);
      rnd = $urandom;
      addr = {rnd[31:8], 6'(off), rnd[1:0]};
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d = 32'($urandom_range(0, 3));
      if (off == 16) d[0] = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        apb(1'b1, addr, d, r, e);
        model_access(1'b1, off, d, mr, me);
      end else begin
        apb(1'b0, addr, 32'h0, r, e);
        model_access(1'b0, off, 32'h0, mr, me);
      end
      check($sformatf("rand%0d_off%0d_rdata", it, off), r, mr);
      check($sformatf("rand%0d_off%0d_err", it, off), e, me);
      @(negedge bus.hclk);
      for (int h = 0; h < H; h++) begin
        exp_tmr[h] = (m_mtime >= m_cmp[h]);
        exp_sfr[h] = m_msip[h];
      end
      check($sformatf("rand%0d_tmr", it), tmr, exp_tmr);
      check($sformatf("rand%0d_sfr", it), sfr, exp_sfr);
    end

    // Reset asserted in the middle of an access phase
    wr(32'h40, 32'h1);
    wr(32'h04, 32'h1);
    check("midrst_sfr_before", sfr[1], 1'b1);
    rtc = 1'b1;
    @(negedge bus.hclk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 32'h0; bus.pwdata = 32'h1;
    @(negedge bus.hclk);
    bus.penable = 1'b1;
    #2 bus.hresetn = 1'b0;
    #1;
    check("midrst_sfr_async", sfr, 0);
    check("midrst_tmr_async", tmr, 0);
    @(negedge bus.hclk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    repeat (2) @(negedge bus.hclk);
    bus.hresetn = 1'b1;
    repeat (12) @(negedge bus.hclk);
    rd_chk("midrst_msip0", 32'h00, 32'h0);
    rd_chk("midrst_ctrl", 32'h40, 32'h1);
    rd_chk("midrst_cmph1", 32'h8C, 32'hFFFF_FFFF);
    rd_chk("midrst_no_stale_tick", 32'h48, 32'h0);
    rtc = 1'b0;
    repeat (5) @(negedge bus.hclk);
    rtc_pulse();
    rd_chk("midrst_fresh_tick", 32'h48, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
